// File: rtl/sdr_bus_pkg.sv
// Shared AHB-Lite bus encodings and register offsets for the frame-tick peripherals.
package sdr_bus_pkg;

  localparam int unsigned BUS_W = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    REG_PEND   = 2'd0,
    REG_MASK   = 2'd1,
    REG_ACTIVE = 2'd2,
    REG_MISS   = 2'd3
  } reg_sel_e;

endpackage

// File: rtl/ahb_slave_if.sv
// Zero-wait-state AHB-Lite slave front end: captures the address phase and
// presents single-cycle read/write strobes plus a register select to a core.
module ahb_slave_if
  import sdr_bus_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              HSEL,
  input  logic [3:0]        HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic              HREADY,
  output logic [BUS_W-1:0]  HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  input  logic [BUS_W-1:0]  rd_data,
  output logic              wr_en,
  output logic              rd_en,
  output reg_sel_e          reg_sel
);

  logic     valid_q;
  logic     write_q;
  reg_sel_e addr_q;
  logic     accept;
  logic     unused_bus_bits;

  // Only NONSEQ/SEQ carry a transfer; IDLE and BUSY share HTRANS[1]=0.
  assign accept = HSEL & HTRANS[1] & HREADY;
  assign unused_bus_bits = ^{HADDR[1:0], HTRANS[0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= REG_PEND;
    end else begin
      valid_q <= accept;
      if (accept) begin
        write_q <= HWRITE;
        addr_q  <= reg_sel_e'(HADDR[3:2]);
      end
    end
  end

  assign wr_en     = valid_q & write_q;
  assign rd_en     = valid_q & ~write_q;
  assign reg_sel   = addr_q;
  assign HRDATA    = rd_en ? rd_data : '0;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

endmodule

// File: rtl/frame_irq_ctrl.sv
// Frame-tick interrupt controller: edge-detected pending bits, mask, W1C clear
// and a saturating counter of events lost to an already-pending bit.
module frame_irq_ctrl
  import sdr_bus_pkg::*;
#(
  parameter int unsigned N_IRQ  = 4,
  parameter int unsigned MISS_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              HSEL,
  input  logic [3:0]        HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic              HREADY,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  input  logic [N_IRQ-1:0]  irq_in,
  output logic              irq_out
);

  localparam int unsigned CNT_W = $clog2(N_IRQ + 1);
  localparam int unsigned SUM_W = MISS_W + CNT_W;
  localparam logic [MISS_W-1:0] MISS_MAX = '1;

  logic [N_IRQ-1:0]  pend;
  logic [N_IRQ-1:0]  mask;
  logic [N_IRQ-1:0]  irq_prev;
  logic [N_IRQ-1:0]  rise;
  logic [N_IRQ-1:0]  hit;
  logic [MISS_W-1:0] miss;
  logic [MISS_W-1:0] miss_next;
  logic [CNT_W-1:0]  miss_inc;
  logic [SUM_W-1:0]  miss_sum;
  logic [31:0]       rd_data;
  logic              wr_en;
  logic              rd_en;
  reg_sel_e          reg_sel;
  logic              wr_pend;
  logic              wr_mask;
  logic              wr_miss;
  logic              unused_hwdata;
  logic              unused_rd_en;

  ahb_slave_if u_ahb_slave_if (
    .clk       (clk),
    .rst_n     (rst_n),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HREADY    (HREADY),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .reg_sel   (reg_sel)
  );

  assign unused_hwdata = ^HWDATA;
  assign unused_rd_en  = rd_en;

  assign wr_pend = wr_en && (reg_sel == REG_PEND);
  assign wr_mask = wr_en && (reg_sel == REG_MASK);
  assign wr_miss = wr_en && (reg_sel == REG_MISS);

  assign rise = irq_in & ~irq_prev;
  assign hit  = rise & pend;

  // A write to MISS clears before this cycle's lost events are added.
  always_comb begin
    miss_inc = '0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      miss_inc = miss_inc + CNT_W'(hit[i]);
    end
    miss_sum = (wr_miss ? '0 : {{CNT_W{1'b0}}, miss}) + SUM_W'(miss_inc);
    if (miss_sum > SUM_W'(MISS_MAX)) begin
      miss_next = MISS_MAX;
    end else begin
      miss_next = miss_sum[MISS_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend     <= '0;
      mask     <= '0;
      miss     <= '0;
      irq_prev <= '0;
    end else begin
      irq_prev <= irq_in;
      miss     <= miss_next;
      // New edges take priority over a same-cycle W1C.
      if (wr_pend) begin
        pend <= (pend & ~HWDATA[N_IRQ-1:0]) | rise;
      end else begin
        pend <= pend | rise;
      end
      if (wr_mask) begin
        mask <= HWDATA[N_IRQ-1:0];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (reg_sel)
      REG_PEND:   rd_data = 32'(pend);
      REG_MASK:   rd_data = 32'(mask);
      REG_ACTIVE: rd_data = 32'(pend & mask);
      REG_MISS:   rd_data = 32'(miss);
      default:    rd_data = '0;
    endcase
  end

  assign irq_out = |(pend & mask);

endmodule

// File: tb/tb_frame_irq_ctrl.sv
// Directed bench for frame_irq_ctrl (N_IRQ=4, MISS_W=16).
module tb_frame_irq_ctrl;

  localparam logic [3:0] A_PEND   = 4'h0;
  localparam logic [3:0] A_MASK   = 4'h4;
  localparam logic [3:0] A_ACTIVE = 4'h8;
  localparam logic [3:0] A_MISS   = 4'hC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        HSEL;
  logic [3:0]  HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [3:0]  irq_in;
  logic        irq_out;

  int n_tests = 0;
  int n_fail  = 0;

  frame_irq_ctrl #(.N_IRQ(4), .MISS_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HREADY    (HREADY),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .irq_in    (irq_in),
    .irq_out   (irq_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HADDR  = 4'h0;
  endtask

  task automatic ahb_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] dp_irq);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
    tick();
    bus_idle();
    HWDATA = data;
    irq_in = dp_irq;
    tick();
    irq_in = 4'h0;
  endtask

  task automatic ahb_read(input logic [3:0] addr, output logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
    tick();
    bus_idle();
    data = HRDATA;
    tick();
  endtask

  task automatic pulse(input logic [3:0] lines);
    irq_in = lines;
    tick();
    irq_in = 4'h0;
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    n_tests++;
    if (irq_out !== 1'b0) begin n_fail++; $display("FAIL reset_irq_out got=%b exp=0", irq_out); end
    n_tests++;
    if (HRDATA !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata_idle got=%h exp=0", HRDATA); end
    n_tests++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
      n_fail++; $display("FAIL reset_ties got=%b%b exp=10", HREADYOUT, HRESP);
    end
    for (int i = 0; i < 4; i++) begin
      logic [3:0] a;
      a = 4'(i * 4);
      ahb_read(a, d);
      n_tests++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL reset_read_%0h got=%h exp=00000000", a, d); end
    end
  endtask

  task automatic test_pend_clear();
    logic [31:0] d;
    ahb_write(A_MASK, 32'h1, 4'h0);
    n_tests++;
    if (irq_out !== 1'b0) begin n_fail++; $display("FAIL pc_irq_before got=%b exp=0", irq_out); end
    irq_in = 4'h1;
    tick();
    irq_in = 4'h0;
    n_tests++;
    if (irq_out !== 1'b1) begin n_fail++; $display("FAIL pc_irq_after_pulse got=%b exp=1", irq_out); end
    tick();
    ahb_read(A_PEND, d);
    n_tests++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL pc_pend got=%h exp=1", d); end
    ahb_read(A_ACTIVE, d);
    n_tests++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL pc_active got=%h exp=1", d); end
    ahb_write(A_PEND, 32'h1, 4'h0);
    n_tests++;
    if (irq_out !== 1'b0) begin n_fail++; $display("FAIL pc_irq_cleared got=%b exp=0", irq_out); end
  endtask

  task automatic test_masked();
    logic [31:0] d;
    pulse(4'h2);
    ahb_read(A_PEND, d);
    n_tests++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL mk_pend got=%h exp=2", d); end
    ahb_read(A_ACTIVE, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL mk_active got=%h exp=0", d); end
    n_tests++;
    if (irq_out !== 1'b0) begin n_fail++; $display("FAIL mk_irq_masked got=%b exp=0", irq_out); end
    ahb_write(A_MASK, 32'h3, 4'h0);
    n_tests++;
    if (irq_out !== 1'b1) begin n_fail++; $display("FAIL mk_irq_unmasked got=%b exp=1", irq_out); end
    ahb_write(A_MASK, 32'hFFFF_FFF3, 4'h0);
    ahb_read(A_MASK, d);
    n_tests++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL mk_mask_upper got=%h exp=3", d); end
    ahb_write(A_PEND, 32'h2, 4'h0);
  endtask

  task automatic test_miss();
    logic [31:0] d;
    pulse(4'h1); pulse(4'h1); pulse(4'h1);
    ahb_read(A_PEND, d);
    n_tests++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL ms_pend got=%h exp=1", d); end
    ahb_read(A_MISS, d);
    n_tests++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL ms_count got=%h exp=2", d); end
    irq_in = 4'h4;
    repeat (10) tick();
    irq_in = 4'h0;
    tick();
    ahb_read(A_PEND, d);
    n_tests++;
    if (d !== 32'h5) begin n_fail++; $display("FAIL ms_level_pend got=%h exp=5", d); end
    ahb_read(A_MISS, d);
    n_tests++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL ms_level_miss got=%h exp=2", d); end
    ahb_write(A_PEND, 32'hF, 4'h0);
    ahb_write(A_MISS, 32'h0, 4'h0);
    pulse(4'hF);
    for (int i = 0; i < 16383; i++) pulse(4'hF);
    ahb_read(A_MISS, d);
    n_tests++;
    if (d !== 32'h0000_FFFC) begin n_fail++; $display("FAIL ms_near_sat got=%h exp=0000fffc", d); end
    pulse(4'hF);
    ahb_read(A_MISS, d);
    n_tests++;
    if (d !== 32'h0000_FFFF) begin n_fail++; $display("FAIL ms_sat got=%h exp=0000ffff", d); end
    pulse(4'hF); pulse(4'h1); pulse(4'hF);
    ahb_read(A_MISS, d);
    n_tests++;
    if (d !== 32'h0000_FFFF) begin n_fail++; $display("FAIL ms_sat_hold got=%h exp=0000ffff", d); end
    ahb_read(A_PEND, d);
    n_tests++;
    if (d !== 32'hF) begin n_fail++; $display("FAIL ms_sat_pend got=%h exp=f", d); end
  endtask

  task automatic test_same_cycle();
    logic [31:0] d;
    ahb_write(A_PEND, 32'hF, 4'h0);
    ahb_write(A_MISS, 32'h0, 4'h0);
    pulse(4'h1);
    ahb_write(A_PEND, 32'h1, 4'h1);
    ahb_read(A_PEND, d);
    n_tests++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL sc_set_wins got=%h exp=1", d); end
    ahb_read(A_MISS, d);
    n_tests++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL sc_w1c_miss got=%h exp=1", d); end
    ahb_write(A_MISS, 32'h0, 4'h1);
    ahb_read(A_MISS, d);
    n_tests++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL sc_clear_then_add got=%h exp=1", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = A_MASK;
    tick();
    HWDATA = 32'hF;
    HTRANS = 2'b10; HWRITE = 1'b0; HADDR = A_MASK;
    tick();
    bus_idle();
    n_tests++;
    if (HRDATA !== 32'hF) begin n_fail++; $display("FAIL bb_read_after_write got=%h exp=f", HRDATA); end
    tick();
    n_tests++;
    if (HRDATA !== 32'h0) begin n_fail++; $display("FAIL bb_hrdata_gated got=%h exp=0", HRDATA); end
    // IDLE, BUSY, unselected and HREADY-low writes must all be ignored.
    for (int k = 0; k < 4; k++) begin
      HSEL   = (k == 2) ? 1'b0 : 1'b1;
      HTRANS = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b10;
      HREADY = (k == 3) ? 1'b0 : 1'b1;
      HWRITE = 1'b1; HADDR = A_MASK;
      tick();
      bus_idle();
      HREADY = 1'b1;
      HWDATA = 32'h0;
      tick();
      ahb_read(A_MASK, d);
      n_tests++;
      if (d !== 32'hF) begin n_fail++; $display("FAIL bb_ignored_%0d got=%h exp=f", k, d); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n  = 1'b0;
    HREADY = 1'b1;
    HWDATA = 32'h0;
    irq_in = 4'h0;
    bus_idle();
    #1;
    test_reset();
    test_pend_clear();
    test_masked();
    test_miss();
    test_same_cycle();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
